// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and default geometry for the sprite fetch engine
package sprite_pkg;

    localparam int DEF_PIXEL_W     = 24;
    localparam int DEF_SPRITE_W    = 16;
    localparam int DEF_SPRITE_H    = 16;
    localparam int DEF_NUM_SPRITES = 32;
    localparam int DEF_COORD_W     = 10;
    localparam int DEF_LAYER_W     = 5;
    localparam logic [23:0] DEF_TRANSPARENT_KEY = 24'hFF00FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Sideband sized for the default coordinate and layer widths
    typedef struct packed {
        logic [DEF_COORD_W-1:0] x;
        logic [DEF_COORD_W-1:0] y;
        logic [DEF_LAYER_W-1:0] layer;
        logic                   last;
    } sprite_sb_t;

endpackage

// File: rtl/sprite_fetch_if.sv
// rtl/sprite_fetch_if.sv - request, sprite ROM and pixel stream signals of the fetch engine
interface sprite_fetch_if
    import sprite_pkg::*;
#(
    parameter int PIXEL_W = DEF_PIXEL_W,
    parameter int COORD_W = DEF_COORD_W,
    parameter int LAYER_W = DEF_LAYER_W,
    parameter int ID_W    = $clog2(DEF_NUM_SPRITES),
    parameter int ADDR_W  = $clog2(DEF_NUM_SPRITES * DEF_SPRITE_W * DEF_SPRITE_H)
);
    logic               req_valid;
    logic               req_ready;
    logic [ID_W-1:0]    req_sprite_id;
    logic [LAYER_W-1:0] req_layer;
    logic [COORD_W-1:0] req_anchor_x;
    logic [COORD_W-1:0] req_anchor_y;
    logic               rom_rden;
    logic [ADDR_W-1:0]  rom_addr;
    logic [PIXEL_W-1:0] rom_q;
    logic               pix_valid;
    logic               pix_ready;
    logic [PIXEL_W-1:0] pix_data;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [LAYER_W-1:0] pix_layer;
    logic               pix_last;
    logic               pix_transp;

    modport master (
        input  req_valid, req_sprite_id, req_layer, req_anchor_x, req_anchor_y, rom_q, pix_ready,
        output req_ready, rom_rden, rom_addr, pix_valid, pix_data, pix_x, pix_y, pix_layer,
               pix_last, pix_transp
    );

    modport slave (
        output req_valid, req_sprite_id, req_layer, req_anchor_x, req_anchor_y, rom_q, pix_ready,
        input  req_ready, rom_rden, rom_addr, pix_valid, pix_data, pix_x, pix_y, pix_layer,
               pix_last, pix_transp
    );

endinterface

// File: rtl/sprite_pix_buf.sv
// rtl/sprite_pix_buf.sv - 2-entry synchronous FIFO holding returned pixels with their sideband
module sprite_pix_buf #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         wr_en;
    logic         rd_en;

    assign rd_en = pop && (count != 2'd0);
    assign wr_en = push && ((count != 2'd2) || rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sprite_fetch.sv
// rtl/sprite_fetch.sv - sprite texel fetch engine; SPRITE_FETCH_TRANSPARENT_KEY_EN enables colour-key dropping
module sprite_fetch
    import sprite_pkg::*;
#(
    parameter int PIXEL_W     = DEF_PIXEL_W,
    parameter int SPRITE_W    = DEF_SPRITE_W,
    parameter int SPRITE_H    = DEF_SPRITE_H,
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int LAYER_W     = DEF_LAYER_W,
    parameter logic [PIXEL_W-1:0] TRANSPARENT_KEY = PIXEL_W'(DEF_TRANSPARENT_KEY)
) (
    input  logic           clock,
    input  logic           rst,
    sprite_fetch_if.master bus,
    output logic           busy
);
    localparam int ID_W   = $clog2(NUM_SPRITES);
    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int ADDR_W = $clog2(NUM_SPRITES * SPRITE_W * SPRITE_H);
    localparam int BUF_W  = PIXEL_W + $bits(sprite_sb_t) + 1;
`ifdef SPRITE_FETCH_TRANSPARENT_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    state_t             state;
    state_t             state_nx;
    logic [ID_W-1:0]    id_q;
    logic [LAYER_W-1:0] layer_q;
    logic [COORD_W-1:0] ax_q;
    logic [COORD_W-1:0] ay_q;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               id_ok;
    logic               accept;
    logic               issue;
    logic               last_issue;
    logic               inflight;
    sprite_sb_t         infl_sb;
    logic [1:0]         occ;
    logic [2:0]         pending;
    logic               pop;
    logic [PIXEL_W-1:0] rx_data;
    logic               keyed;
    logic               push;
    logic [BUF_W-1:0]   head;
    logic [PIXEL_W-1:0] head_data;
    sprite_sb_t         head_sb;
    logic               head_transp;
    logic               buf_valid;

    assign id_ok      = 32'(id_q) < 32'(NUM_SPRITES);
    assign buf_valid  = (occ != 2'd0);
    assign pop        = buf_valid && bus.pix_ready;
    // Reads already issued plus buffered pixels must never exceed the two buffer slots
    assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign last_issue = issue && (&col) && (&row);

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = FETCH;
            FETCH:   if (last_issue) state_nx = DRAIN;
            DRAIN:   if (pop && head_sb.last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE) && !rst;
        busy          = (state != IDLE);
        issue         = (state == FETCH) && (pending < 3'd2);
        accept        = bus.req_valid && bus.req_ready;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            id_q     <= '0;
            layer_q  <= '0;
            ax_q     <= '0;
            ay_q     <= '0;
            col      <= '0;
            row      <= '0;
            inflight <= 1'b0;
            infl_sb  <= '0;
        end else begin
            inflight <= issue;
            if (accept) begin
                id_q    <= bus.req_sprite_id;
                layer_q <= bus.req_layer;
                ax_q    <= bus.req_anchor_x;
                ay_q    <= bus.req_anchor_y;
                col     <= '0;
                row     <= '0;
            end else if (issue) begin
                col <= col + 1'b1;
                if (&col) begin
                    row <= row + 1'b1;
                end
            end
            if (issue) begin
                infl_sb.x     <= ax_q + COORD_W'(col);
                infl_sb.y     <= ay_q + COORD_W'(row);
                infl_sb.layer <= layer_q;
                infl_sb.last  <= (&col) && (&row);
            end
        end
    end

    // Out-of-range sprites still walk the full raster, but without touching the ROM
    assign bus.rom_rden = issue && id_ok;
    assign bus.rom_addr = ADDR_W'({id_q, row, col});

    assign rx_data = id_ok ? bus.rom_q : '0;
    assign keyed   = KEY_EN && (rx_data == TRANSPARENT_KEY);
    assign push    = inflight && (!keyed || infl_sb.last);

    sprite_pix_buf #(
        .W(BUF_W)
    ) u_buf (
        .clock    (clock),
        .rst      (rst),
        .push     (push),
        .push_data({rx_data, infl_sb, keyed}),
        .pop      (pop),
        .head     (head),
        .count    (occ)
    );

    assign {head_data, head_sb, head_transp} = head;

    assign bus.pix_valid  = buf_valid;
    assign bus.pix_data   = head_data;
    assign bus.pix_x      = head_sb.x;
    assign bus.pix_y      = head_sb.y;
    assign bus.pix_layer  = head_sb.layer;
    assign bus.pix_last   = buf_valid && head_sb.last;
    assign bus.pix_transp = buf_valid && head_transp;

endmodule
